// File: rtl/jk_bank_driver.sv
// Drives J/K excitations into a shared-clock JK flip-flop bank, verifies the result, retries, reports errors.
// Optional build macro JK_DRV_TOGGLE_EN: drive changing bits with J=K=1 (toggle) instead of set/reset.
module jk_bank_driver #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] fail_mask
);

  localparam int unsigned RETRY_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [WIDTH-1:0]     tgt_r, tgt_n;
  logic [RETRY_W-1:0]   retry_cnt, retry_n;
  logic [WIDTH-1:0]     j_n, k_n, fail_n;
  logic                 done_n, err_n;

  // Per-bit excitation needed to move the bank from cur to nxt in one capture.
  function automatic logic [WIDTH-1:0] exc_j(input logic [WIDTH-1:0] cur, input logic [WIDTH-1:0] nxt);
`ifdef JK_DRV_TOGGLE_EN
    return cur ^ nxt;
`else
    return ~cur & nxt;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] exc_k(input logic [WIDTH-1:0] cur, input logic [WIDTH-1:0] nxt);
`ifdef JK_DRV_TOGGLE_EN
    return cur ^ nxt;
`else
    return cur & ~nxt;
`endif
  endfunction

  // Next-state and next-output logic; J/K default to zero so they only pulse for one DRIVE cycle.
  always_comb begin
    state_n = state;
    tgt_n   = tgt_r;
    retry_n = retry_cnt;
    j_n     = '0;
    k_n     = '0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    fail_n  = fail_mask;
    case (state)
      IDLE: begin
        if (req_valid) begin
          tgt_n   = req_target;
          retry_n = '0;
          fail_n  = '0;
          j_n     = exc_j(q_in, req_target);
          k_n     = exc_k(q_in, req_target);
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        state_n = CHECK;
      end
      CHECK: begin
        if (q_in == tgt_r) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
          retry_n = retry_cnt + RETRY_W'(1);
          j_n     = exc_j(q_in, tgt_r);
          k_n     = exc_k(q_in, tgt_r);
          state_n = DRIVE;
        end else begin
          err_n   = 1'b1;
          fail_n  = q_in ^ tgt_r;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs; req_ready/busy track the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tgt_r     <= '0;
      retry_cnt <= '0;
      j_out     <= '0;
      k_out     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      fail_mask <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      tgt_r     <= tgt_n;
      retry_cnt <= retry_n;
      j_out     <= j_n;
      k_out     <= k_n;
      done      <= done_n;
      err       <= err_n;
      fail_mask <= fail_n;
      req_ready <= (state_n == IDLE);
      busy      <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver with a behavioural JK bank (loadable, stuck-bit and missed-capture faults).
module tb_jk_bank_driver;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_target;
  logic [7:0] q_in;
  logic [7:0] j_out;
  logic [7:0] k_out;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] fail_mask;

  logic [7:0] bank_q;
  logic       load_en;
  logic [7:0] load_val;
  logic       stuck3;
  logic       miss_arm;
  logic       miss_done;

  int n_chk;
  int n_fail;

  jk_bank_driver #(.WIDTH(8), .MAX_RETRY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .q_in(q_in), .j_out(j_out), .k_out(k_out),
    .busy(busy), .done(done), .err(err), .fail_mask(fail_mask)
  );

  always #5 clk = ~clk;
  assign q_in = bank_q;

  // JK bank model sharing the driver clock.
  always @(posedge clk) begin
    if (load_en) begin
      bank_q    <= load_val;
      miss_done <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (!(i == 0 && miss_arm && !miss_done)) begin
          case ({j_out[i], k_out[i]})
            2'b10:   bank_q[i] <= 1'b1;
            2'b01:   bank_q[i] <= 1'b0;
            2'b11:   bank_q[i] <= ~bank_q[i];
            default: ;
          endcase
        end
      end
      if (miss_arm && !miss_done && (j_out[0] | k_out[0])) miss_done <= 1'b1;
      if (stuck3) bank_q[3] <= 1'b0;
    end
  end

  task automatic load_bank(input logic [7:0] v);
    @(negedge clk);
    load_en  = 1'b1;
    load_val = v;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  // Offer a target and return at the negedge after the accept edge E0.
  task automatic accept(input logic [7:0] t);
    @(negedge clk);
    req_valid  = 1'b1;
    req_target = t;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; req_valid = 1'b1; req_target = 8'hA5;
    load_bank(8'h00);
    @(negedge clk);
    n_chk++;
    if ({req_ready, busy, done, err} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 1000", {req_ready, busy, done, err});
    end
    n_chk++;
    if ({j_out, k_out, fail_mask} !== 24'h0) begin
      n_fail++; $display("FAIL reset_vec: got %h want 000000", {j_out, k_out, fail_mask});
    end
    req_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_set;
    load_bank(8'h00);
    accept(8'hA5);
    n_chk++;
    if ({j_out, k_out, busy, req_ready} !== {8'hA5, 8'h00, 2'b10}) begin
      n_fail++; $display("FAIL set_drive: got j=%h k=%h busy=%b rdy=%b want j=a5 k=00 busy=1 rdy=0", j_out, k_out, busy, req_ready);
    end
    @(negedge clk);
    n_chk++;
    if ({j_out, k_out, busy, done} !== {8'h00, 8'h00, 2'b10}) begin
      n_fail++; $display("FAIL set_check: got j=%h k=%h busy=%b done=%b want 00 00 1 0", j_out, k_out, busy, done);
    end
    @(negedge clk);
    n_chk++;
    if ({done, err, req_ready, busy, bank_q} !== {4'b1010, 8'hA5}) begin
      n_fail++; $display("FAIL set_done: got done=%b err=%b rdy=%b busy=%b bank=%h want 1 0 1 0 a5", done, err, req_ready, busy, bank_q);
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL set_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_clear;
    logic [7:0] ej, ek;
`ifdef JK_DRV_TOGGLE_EN
    ej = 8'hF0; ek = 8'hF0;
`else
    ej = 8'h00; ek = 8'hF0;
`endif
    load_bank(8'hFF);
    accept(8'h0F);
    n_chk++;
    if ({j_out, k_out} !== {ej, ek}) begin
      n_fail++; $display("FAIL clr_drive: got j=%h k=%h want j=%h k=%h", j_out, k_out, ej, ek);
    end
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({done, err, bank_q} !== {2'b10, 8'h0F}) begin
      n_fail++; $display("FAIL clr_done: got done=%b err=%b bank=%h want 1 0 0f", done, err, bank_q);
    end
  endtask

  task automatic test_equal;
    load_bank(8'h3C);
    accept(8'h3C);
    n_chk++;
    if ({j_out, k_out, busy} !== {16'h0000, 1'b1}) begin
      n_fail++; $display("FAIL eq_drive: got j=%h k=%h busy=%b want 00 00 1", j_out, k_out, busy);
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL eq_early: got done=%b want 0", done);
    end
    @(negedge clk);
    n_chk++;
    if ({done, err, bank_q} !== {2'b10, 8'h3C}) begin
      n_fail++; $display("FAIL eq_done: got done=%b err=%b bank=%h want 1 0 3c", done, err, bank_q);
    end
  endtask

  task automatic test_retry_err;
    int drives, err_at, err_hits, done_hits;
    drives = 0; err_at = -1; err_hits = 0; done_hits = 0;
    stuck3 = 1'b1;
    load_bank(8'h00);
    accept(8'h08);
    for (int e = 0; e < 8; e++) begin
      if (e > 0) @(negedge clk);
      if (j_out === 8'h08) drives++;
      if (err === 1'b1) begin err_hits++; err_at = e; end
      if (done === 1'b1) done_hits++;
    end
    n_chk++;
    if (drives != 3) begin
      n_fail++; $display("FAIL err_drives: got %0d want 3", drives);
    end
    n_chk++;
    if (err_at != 6 || err_hits != 1 || done_hits != 0) begin
      n_fail++; $display("FAIL err_pulse: got at=%0d hits=%0d done=%0d want 6 1 0", err_at, err_hits, done_hits);
    end
    n_chk++;
    if ({fail_mask, req_ready} !== {8'h08, 1'b1}) begin
      n_fail++; $display("FAIL err_mask: got mask=%h rdy=%b want 08 1", fail_mask, req_ready);
    end
    stuck3 = 1'b0;
  endtask

  task automatic test_retry_ok;
    miss_arm = 1'b1;
    load_bank(8'h00);
    accept(8'h01);
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({j_out, k_out, done, busy} !== {8'h01, 8'h00, 2'b01}) begin
      n_fail++; $display("FAIL rty_redrive: got j=%h k=%h done=%b busy=%b want 01 00 0 1", j_out, k_out, done, busy);
    end
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({done, err, bank_q, fail_mask} !== {2'b10, 8'h01, 8'h00}) begin
      n_fail++; $display("FAIL rty_done: got done=%b err=%b bank=%h mask=%h want 1 0 01 00", done, err, bank_q, fail_mask);
    end
    miss_arm = 1'b0;
  endtask

  task automatic test_reset_mid;
    int bad;
    bad = 0;
    load_bank(8'h00);
    accept(8'h5A);
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if ({j_out, k_out, busy, req_ready, done, err} !== {16'h0000, 4'b0100}) begin
      n_fail++; $display("FAIL rst_mid: got j=%h k=%h busy=%b rdy=%b done=%b err=%b want 00 00 0 1 0 0", j_out, k_out, busy, req_ready, done, err);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || err !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0 || bank_q !== 8'h00) begin
      n_fail++; $display("FAIL rst_quiet: got pulses=%0d bank=%h want 0 00", bad, bank_q);
    end
    reset = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [7:0] ej, ek;
`ifdef JK_DRV_TOGGLE_EN
    ej = 8'h33; ek = 8'h33;
`else
    ej = 8'h22; ek = 8'h11;
`endif
    load_bank(8'h00);
    @(negedge clk);
    req_valid = 1'b1; req_target = 8'h11;
    @(negedge clk);
    req_target = 8'h22;
    @(negedge clk);
    n_chk++;
    if ({j_out, busy, req_ready} !== {8'h00, 2'b10}) begin
      n_fail++; $display("FAIL b2b_hold: got j=%h busy=%b rdy=%b want 00 1 0", j_out, busy, req_ready);
    end
    @(negedge clk);
    n_chk++;
    if ({done, req_ready, bank_q} !== {2'b11, 8'h11}) begin
      n_fail++; $display("FAIL b2b_first: got done=%b rdy=%b bank=%h want 1 1 11", done, req_ready, bank_q);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_chk++;
    if ({j_out, k_out, done, busy} !== {ej, ek, 2'b01}) begin
      n_fail++; $display("FAIL b2b_second: got j=%h k=%h done=%b busy=%b want %h %h 0 1", j_out, k_out, done, busy, ej, ek);
    end
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({done, err, bank_q} !== {2'b10, 8'h22}) begin
      n_fail++; $display("FAIL b2b_done: got done=%b err=%b bank=%h want 1 0 22", done, err, bank_q);
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0; req_valid = 1'b0; req_target = 8'h00;
    load_en = 1'b0; load_val = 8'h00; stuck3 = 1'b0; miss_arm = 1'b0;
    n_chk = 0; n_fail = 0;
    test_reset;
    test_set;
    test_clear;
    test_equal;
    test_retry_err;
    test_retry_ok;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_bank_driver.md
# jk_bank_driver

Controller for a bank of JK flip-flops sharing one clock. It accepts a target word over a valid/ready handshake and reads the bank's present Q outputs. It then drives per-bit J/K excitations for one cycle and checks that the bank reached the target. If the bank has not reached the target, it retries a bounded number of times and then reports an error.

## Interface
Parameters:
- WIDTH, 8, number of flip-flops in the driven bank (1..32)
- MAX_RETRY, 2, extra DRIVE/CHECK passes allowed after the first mismatch (0..7)

Ports:
- clk  input  1  clock; shared with the driven JK bank
- reset  input  1  reset, asynchronous, active-low
- req_valid  input  1  target word offered
- req_ready  output  1  driver can accept a target; high exactly when state is IDLE
- req_target  input  WIDTH  desired bank state
- q_in  input  WIDTH  Q outputs of the driven bank
- j_out  output  WIDTH  J inputs to the bank, registered
- k_out  output  WIDTH  K inputs to the bank, registered
- busy  output  1  high in DRIVE or CHECK
- done  output  1  one-cycle pulse: bank matched target
- err  output  1  one-cycle pulse: retries exhausted without a match
- fail_mask  output  WIDTH  bits still mismatching at err; held until next accept

## Operation
- States: IDLE, DRIVE, CHECK. Encoding is free; the state must be held in a register.
- IDLE:
  - req_ready=1; j_out=k_out=0.
  - On req_valid&&req_ready, latch req_target into tgt_r.
  - Clear retry_cnt to 0 and fail_mask to 0.
  - Register the excitation computed from q_in and req_target into j_out/k_out, then go to DRIVE.
- Excitation per bit i, with cur=q_in[i] and nxt=target[i] (default build):
  - 0->0: J=0, K=0
  - 0->1: J=1, K=0
  - 1->0: J=0, K=1
  - 1->1: J=0, K=0
  - J=K=1 is never driven.
- DRIVE: lasts exactly one cycle with j_out/k_out stable. At the next edge, clear j_out/k_out to 0 and go to CHECK.
- CHECK: lasts one cycle; compare q_in with tgt_r at the closing edge.
  - Match: done<=1, go to IDLE.
  - Mismatch and retry_cnt<MAX_RETRY: retry_cnt++, register a fresh excitation from current q_in and tgt_r, go to DRIVE.
  - Mismatch and retry_cnt==MAX_RETRY: err<=1, fail_mask<=q_in^tgt_r, go to IDLE.
- A target equal to current q_in still takes the full DRIVE/CHECK path (all-zero excitation) and ends with done.
- req_valid while busy is ignored; the latched tgt_r is not disturbed.
- done and err are mutually exclusive and never high for more than one cycle.

## Timing
- Reset values (asserted asynchronously):
  - state IDLE, so req_ready=1 even while reset is low
  - j_out=0, k_out=0, busy=0, done=0, err=0, fail_mask=0, retry_cnt=0
- Reset mid-operation aborts immediately: J/K drop to 0 with no done/err pulse.
- Success latency:
  - accept edge E0
  - bank captures J/K at E1
  - driver samples q_in at E2
  - done high from E2 to E3, in the same cycle req_ready returns to 1
- A new request may be accepted at E3; back-to-back throughput is one target per 3 cycles.
- Each retry adds 2 cycles. Worst-case err appears 2*(MAX_RETRY+1) edges after accept.
- q_in must not be sampled combinationally into J/K outside the accept edge or the CHECK closing edge.

## Configuration
- JK_DRV_TOGGLE_EN defined:
  - Changing bits (0->1 and 1->0) are driven J=1, K=1 (toggle). Unchanged bits stay J=K=0.
  - This exercises the bank's toggle path and makes a stale q_in produce a detectable mismatch.
- JK_DRV_TOGGLE_EN undefined: set/reset encoding as in Operation; J=K=1 never appears.

## Test plan
- Reset low with req_valid=1: all outputs 0 and req_ready=1. Release reset, bank at 0x00, target 0xA5 -> j_out=0xA5, k_out=0x00 for one cycle, done at E2->E3, bank reads 0xA5.
- Bank 0xFF, target 0x0F -> j_out=0x00, k_out=0xF0; done, bank reads 0x0F. With JK_DRV_TOGGLE_EN: j_out=k_out=0xF0, same final result.
- Target equals bank value 0x3C -> j_out=k_out=0x00 for the DRIVE cycle, done after 2 edges.
- Bank model forces bit 3 stuck at 0 and target 0x08, MAX_RETRY=2 -> three DRIVE cycles with j_out=0x08, err pulse at edge 6, fail_mask=0x08, no done.
- Bank bit 0 misses the first capture and is corrected on retry, target 0x01 -> one retry, done at edge 4, retry path recomputes from current q_in.
- Assert reset during DRIVE -> j_out/k_out=0 immediately, no done/err. Hold req_valid while busy -> no second accept until req_ready=1.
